// File: rtl/cpci_dma_pkg.sv
// Shared types and encodings for the CPCI DMA scheduler.
package cpci_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_UPD,
      ST_FIN
   } state_t;

   localparam logic [1:0] MST_OK     = 2'b00;
   localparam logic [1:0] MST_RETRY  = 2'b01;
   localparam logic [1:0] MST_MABORT = 2'b10;
   localparam logic [1:0] MST_TABORT = 2'b11;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_RETRY  = 2'b01;
   localparam logic [1:0] ERR_MABORT = 2'b10;
   localparam logic [1:0] ERR_TABORT = 2'b11;

   function automatic logic is_abort(input logic [1:0] st);
      return st == MST_MABORT || st == MST_TABORT;
   endfunction

endpackage

// File: rtl/cpci_dma_sched_if.sv
// Burst request/completion bus between the scheduler and the PCI master core.
interface cpci_dma_sched_if #(
   parameter int ADDR_W = 32
);
   logic              mst_req;
   logic              mst_wr;
   logic [ADDR_W-1:0] mst_addr;
   logic [4:0]        mst_cnt;
   logic              mst_ack;
   logic              mst_done;
   logic [4:0]        mst_xfer_cnt;
   logic [1:0]        mst_status;

   modport master (
      output mst_req, mst_wr, mst_addr, mst_cnt,
      input  mst_ack, mst_done, mst_xfer_cnt, mst_status
   );

   modport slave (
      input  mst_req, mst_wr, mst_addr, mst_cnt,
      output mst_ack, mst_done, mst_xfer_cnt, mst_status
   );
endinterface

// File: rtl/cpci_dma_burst_len.sv
// Burst size: min of MAX_BURST, remaining words and words left in the 4 KB page.
module cpci_dma_burst_len #(
   parameter int LEN_W     = 12,
   parameter int MAX_BURST = 16
) (
   input  logic [LEN_W-1:0] rem_i,
   input  logic [9:0]       wofs_i,
   output logic [4:0]       cnt_o
);
   logic [10:0] to4k;
   logic [4:0]  lim;

   assign to4k = 11'd1024 - 11'(wofs_i);

   always_comb begin
      lim = 5'(MAX_BURST);
      if (rem_i < LEN_W'(MAX_BURST)) lim = rem_i[4:0];
      if (to4k < 11'(lim)) lim = to4k[4:0];
   end

   assign cnt_o = lim;
endmodule

// File: rtl/cpci_dma_sched.sv
// CPCI DMA scheduler: splits a programmed transfer into PCI master bursts
// and reports done/error/interrupt status back to the register file.
module cpci_dma_sched
   import cpci_dma_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 12,
   parameter int MAX_BURST = 16,
   parameter int RETRY_MAX = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dma_start,
   input  logic              dma_dir,
   input  logic [ADDR_W-1:0] dma_host_addr,
   input  logic [LEN_W-1:0]  dma_len,
   output logic              dma_busy,
   output logic              dma_done,
   output logic              dma_err,
   output logic [1:0]        dma_err_code,
   input  logic              int_en,
   input  logic              int_clr,
   output logic              intr_pend,
   cpci_dma_sched_if.master  mst
);
   localparam int RW = $clog2(RETRY_MAX + 1);

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [4:0]        xfer_q, xfer_d;
   logic [1:0]        stat_q, stat_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic              intr_q, intr_d;

   logic [4:0]        cnt_w;
   logic [LEN_W-1:0]  rem_nx;
   logic [RW:0]       retry_nx;
   logic              fin;

   cpci_dma_burst_len #(
      .LEN_W     (LEN_W),
      .MAX_BURST (MAX_BURST)
   ) u_blen (
      .rem_i  (rem_q),
      .wofs_i (addr_q[11:2]),
      .cnt_o  (cnt_w)
   );

   assign rem_nx   = rem_q - LEN_W'(xfer_q);
   assign retry_nx = {1'b0, retry_q} + 1'b1;
   assign fin      = (state_q == ST_FIN);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      retry_d = retry_q;
      xfer_d  = xfer_q;
      stat_d  = stat_q;
      err_d   = err_q;
      code_d  = code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (dma_start) begin
               dir_d   = dma_dir;
               addr_d  = dma_host_addr & ~ADDR_W'(3);
               rem_d   = dma_len;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               retry_d = '0;
               state_d = (dma_len == '0) ? ST_FIN : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mst.mst_ack) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mst.mst_done) begin
               xfer_d  = mst.mst_xfer_cnt;
               stat_d  = mst.mst_status;
               state_d = ST_UPD;
            end
         end
         ST_UPD: begin
            // Partial progress is applied even when the burst aborted.
            addr_d  = addr_q + ADDR_W'({xfer_q, 2'b00});
            rem_d   = rem_nx;
            state_d = ST_REQ;
            if (is_abort(stat_q)) begin
               err_d   = 1'b1;
               code_d  = (stat_q == MST_MABORT) ? ERR_MABORT : ERR_TABORT;
               state_d = ST_FIN;
            end else if (rem_nx == '0) begin
               state_d = ST_FIN;
            end else if (xfer_q != '0) begin
               retry_d = '0;
            end else if (stat_q == MST_RETRY) begin
               retry_d = retry_nx[RW-1:0];
               if (retry_nx == (RW+1)'(RETRY_MAX)) begin
                  err_d   = 1'b1;
                  code_d  = ERR_RETRY;
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A set from FIN takes priority over a coincident clear.
   always_comb begin
      intr_d = intr_q;
      if (fin && int_en) intr_d = 1'b1;
      else if (int_clr)  intr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dir_q   <= 1'b0;
         addr_q  <= '0;
         rem_q   <= '0;
         retry_q <= '0;
         xfer_q  <= '0;
         stat_q  <= MST_OK;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         intr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         retry_q <= retry_d;
         xfer_q  <= xfer_d;
         stat_q  <= stat_d;
         err_q   <= err_d;
         code_q  <= code_d;
         intr_q  <= intr_d;
      end
   end

   assign mst.mst_req  = (state_q == ST_REQ);
   assign mst.mst_wr   = dir_q;
   assign mst.mst_addr = addr_q;
   assign mst.mst_cnt  = (state_q == ST_REQ) ? cnt_w : 5'd0;

   assign dma_busy     = (state_q != ST_IDLE);
   assign dma_done     = fin;
   assign dma_err      = err_q;
   assign dma_err_code = code_q;
   assign intr_pend    = intr_q | (fin & int_en);
endmodule

// File: tb/tb_cpci_dma_sched.sv
// Bench for cpci_dma_sched: directed vector table, reset/interrupt corners
// and randomized transfers against a burst-level reference model.
module tb_cpci_dma_sched;
   import cpci_dma_pkg::*;

   localparam int RETRY_MAX = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        dma_start, dma_dir;
   logic [31:0] dma_host_addr;
   logic [11:0] dma_len;
   logic        dma_busy, dma_done, dma_err;
   logic [1:0]  dma_err_code;
   logic        int_en, int_clr, intr_pend;

   int checks = 0;
   int errors = 0;
   bit exp_intr;

   cpci_dma_sched_if #(.ADDR_W(32)) mst ();

   cpci_dma_sched dut (
      .clk           (clk),
      .reset         (reset),
      .dma_start     (dma_start),
      .dma_dir       (dma_dir),
      .dma_host_addr (dma_host_addr),
      .dma_len       (dma_len),
      .dma_busy      (dma_busy),
      .dma_done      (dma_done),
      .dma_err       (dma_err),
      .dma_err_code  (dma_err_code),
      .int_en        (int_en),
      .int_clr       (int_clr),
      .intr_pend     (intr_pend),
      .mst           (mst)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;
      int          len;
      bit          dir;
      bit          ien;
      int          mode;
      bit          clr;
      int          nreq;
      bit          err;
      logic [1:0]  code;
      logic [31:0] fa;
      int          fc;
      logic [31:0] la;
      int          lc;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   // Master core response script per burst.
   task automatic resp(input int mode, input int idx, input int cnt,
                       output int xf, output logic [1:0] st);
      int p;
      xf = cnt;
      st = MST_OK;
      case (mode)
         1: if (idx == 0) begin xf = 5; st = MST_RETRY; end
         2: begin xf = 0; st = MST_RETRY; end
         3: if (idx == 1) begin xf = 3; st = MST_MABORT; end
         4: begin
            p = $urandom_range(0, 99);
            if (p < 4) begin
               xf = $urandom_range(0, cnt); st = MST_TABORT;
            end else if (p < 8) begin
               xf = $urandom_range(0, cnt); st = MST_MABORT;
            end else if (p < 40) begin
               xf = $urandom_range(0, cnt); st = MST_RETRY;
            end else if (p < 60) begin
               xf = $urandom_range(1, cnt);
            end
         end
         default: ;
      endcase
   endtask

   task automatic run_xfer(input logic [31:0] a0, input int len,
                           input bit dir, input bit ien,
                           input int mode, input bit clr,
                           output int nreq,
                           output logic [31:0] fa, output int fc,
                           output logic [31:0] la, output int lc,
                           output bit e_err, output logic [1:0] e_code);
      logic [31:0] a;
      int          r, retries, cnt, xf, d;
      logic [1:0]  st;
      bit          fin, ifin;
      a = a0 & 32'hFFFF_FFFC;
      r = len;
      retries = 0;
      nreq = 0;
      fa = 0; fc = 0; la = 0; lc = 0;
      e_err = 0; e_code = ERR_NONE;
      fin = (len == 0);
      int_en = ien;
      dma_start = 1; dma_dir = dir;
      dma_host_addr = a0; dma_len = 12'(len);
      @(negedge clk);
      dma_start = 0; dma_dir = ~dir;
      dma_host_addr = $urandom; dma_len = 12'($urandom);
      chk("busy_after_start", dma_busy, 1);
      chk("err_clr_on_start", dma_err, 0);
      while (!fin && nreq < 1000) begin
         cnt = min3(16, r, (4096 - int'(a & 32'hFFF)) / 4);
         chk("req", mst.mst_req, 1);
         chk("req_addr", mst.mst_addr, a);
         chk("req_cnt", mst.mst_cnt, cnt);
         chk("req_wr", mst.mst_wr, dir);
         chk("req_no_done", dma_done, 0);
         if (nreq == 0) begin fa = a; fc = cnt; end
         la = a; lc = cnt;
         nreq++;
         d = $urandom_range(0, 2);
         repeat (d) begin
            @(negedge clk);
            chk("req_hold", mst.mst_req, 1);
            chk("req_addr_hold", mst.mst_addr, a);
            chk("req_cnt_hold", mst.mst_cnt, cnt);
         end
         mst.mst_ack = 1;
         @(negedge clk);
         mst.mst_ack = 0;
         chk("req_drop", mst.mst_req, 0);
         resp(mode, nreq - 1, cnt, xf, st);
         d = $urandom_range(0, 2);
         repeat (d) begin
            dma_start = 1'($urandom_range(0, 1));
            @(negedge clk);
            dma_start = 0;
            chk("wait_no_req", mst.mst_req, 0);
            chk("wait_busy", dma_busy, 1);
         end
         mst.mst_done = 1;
         mst.mst_xfer_cnt = 5'(xf);
         mst.mst_status = st;
         @(negedge clk);
         mst.mst_done = 0;
         mst.mst_xfer_cnt = 5'($urandom);
         mst.mst_status = 2'($urandom);
         chk("upd_no_req", mst.mst_req, 0);
         chk("upd_no_done", dma_done, 0);
         a = a + 32'(4 * xf);
         r = r - xf;
         if (st == MST_MABORT || st == MST_TABORT) begin
            e_err = 1; e_code = st; fin = 1;
         end else if (r == 0) begin
            fin = 1;
         end else if (xf > 0) begin
            retries = 0;
         end else if (st == MST_RETRY) begin
            retries++;
            if (retries == RETRY_MAX) begin
               e_err = 1; e_code = ERR_RETRY; fin = 1;
            end
         end
         @(negedge clk);
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL xfer_budget: got %0d bursts want completion", nreq);
      end
      ifin = exp_intr | ien;
      chk("done", dma_done, 1);
      chk("fin_busy", dma_busy, 1);
      chk("fin_no_req", mst.mst_req, 0);
      chk("fin_err", dma_err, e_err);
      chk("fin_code", dma_err_code, e_code);
      chk("fin_intr", intr_pend, ifin);
      int_clr = clr;
      @(negedge clk);
      int_clr = 0;
      exp_intr = ien ? 1'b1 : (clr ? 1'b0 : exp_intr);
      chk("done_pulse", dma_done, 0);
      chk("idle", dma_busy, 0);
      chk("intr_after", intr_pend, exp_intr);
      chk("err_sticky", dma_err, e_err);
      chk("code_sticky", dma_err_code, e_code);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"}, dma_busy, 0);
      chk({pfx, "_done"}, dma_done, 0);
      chk({pfx, "_err"}, dma_err, 0);
      chk({pfx, "_code"}, dma_err_code, 0);
      chk({pfx, "_intr"}, intr_pend, 0);
      chk({pfx, "_req"}, mst.mst_req, 0);
      chk({pfx, "_wr"}, mst.mst_wr, 0);
      chk({pfx, "_addr"}, mst.mst_addr, 0);
      chk({pfx, "_cnt"}, mst.mst_cnt, 0);
   endtask

   initial begin
      int          nreq, fc, lc, len;
      logic [31:0] fa, la, a;
      bit          e_err;
      logic [1:0]  e_code;

      tbl[0] = '{32'hC000_0100, 128, 0, 1, 0, 0, 8, 0, 2'b00,
                 32'hC000_0100, 16, 32'hC000_02C0, 16};
      tbl[1] = '{32'hC000_0FF0, 10, 0, 1, 0, 1, 2, 0, 2'b00,
                 32'hC000_0FF0, 4, 32'hC000_1000, 6};
      tbl[2] = '{32'h0000_1000, 16, 0, 0, 1, 0, 2, 0, 2'b00,
                 32'h0000_1000, 16, 32'h0000_1014, 11};
      tbl[3] = '{32'h0000_2000, 20, 0, 0, 2, 0, 255, 1, 2'b01,
                 32'h0000_2000, 16, 32'h0000_2000, 16};
      tbl[4] = '{32'h0000_3000, 64, 0, 0, 3, 1, 2, 1, 2'b10,
                 32'h0000_3000, 16, 32'h0000_3040, 16};
      tbl[5] = '{32'h0000_4000, 32, 1, 1, 0, 0, 2, 0, 2'b00,
                 32'h0000_4000, 16, 32'h0000_4040, 16};
      tbl[6] = '{32'h0000_5003, 0, 0, 1, 0, 0, 0, 0, 2'b00,
                 32'h0, 0, 32'h0, 0};
      tbl[7] = '{32'hFFFF_FFF8, 8, 1, 0, 0, 0, 2, 0, 2'b00,
                 32'hFFFF_FFF8, 2, 32'h0000_0000, 6};
      tbl[8] = '{32'h0000_0FFF, 3, 0, 0, 0, 0, 2, 0, 2'b00,
                 32'h0000_0FFC, 1, 32'h0000_1000, 2};

      reset = 1;
      dma_start = 0; dma_dir = 0; dma_host_addr = 0; dma_len = 0;
      int_en = 0; int_clr = 0;
      mst.mst_ack = 0; mst.mst_done = 0;
      mst.mst_xfer_cnt = 0; mst.mst_status = 0;
      exp_intr = 0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 0;
      @(negedge clk);
      chk("post_reset_idle", dma_busy, 0);

      for (int i = 0; i < 9; i++) begin
         run_xfer(tbl[i].addr, tbl[i].len, tbl[i].dir, tbl[i].ien,
                  tbl[i].mode, tbl[i].clr,
                  nreq, fa, fc, la, lc, e_err, e_code);
         chk($sformatf("v%0d_nreq", i), nreq, tbl[i].nreq);
         chk($sformatf("v%0d_err", i), e_err, tbl[i].err);
         chk($sformatf("v%0d_code", i), e_code, tbl[i].code);
         chk($sformatf("v%0d_first_addr", i), fa, tbl[i].fa);
         chk($sformatf("v%0d_first_cnt", i), fc, tbl[i].fc);
         chk($sformatf("v%0d_last_addr", i), la, tbl[i].la);
         chk($sformatf("v%0d_last_cnt", i), lc, tbl[i].lc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      int_clr = 1;
      @(negedge clk);
      int_clr = 0;
      exp_intr = 0;
      chk("int_clr_idle", intr_pend, 0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 1)
            a = (a & 32'hFFFF_F000) | 32'($urandom_range(12'hFC0, 12'hFFF));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4)
                                           : $urandom_range(1, 120);
         run_xfer(a, len, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4,
                  1'($urandom_range(0, 1)),
                  nreq, fa, fc, la, lc, e_err, e_code);
         if ($urandom_range(0, 3) == 0) begin
            int_clr = 1;
            @(negedge clk);
            int_clr = 0;
            exp_intr = 0;
            chk("rand_int_clr", intr_pend, 0);
         end
      end

      run_xfer(32'h0000_8000, 4, 1, 1, 0, 0,
               nreq, fa, fc, la, lc, e_err, e_code);
      int_en = 1;
      dma_start = 1; dma_dir = 1;
      dma_host_addr = 32'h0000_6000; dma_len = 12'd32;
      @(negedge clk);
      dma_start = 0;
      chk("rst_pre_req", mst.mst_req, 1);
      mst.mst_ack = 1;
      @(negedge clk);
      mst.mst_ack = 0;
      chk("rst_pre_wait", mst.mst_req, 0);
      chk("rst_pre_intr", intr_pend, 1);
      reset = 1;
      @(negedge clk);
      chk_zero("rst_wait");
      reset = 0;
      exp_intr = 0;
      @(negedge clk);
      chk("rst_post_idle", dma_busy, 0);

      run_xfer(32'h0000_7FC0, 40, 0, 0, 0, 0,
               nreq, fa, fc, la, lc, e_err, e_code);
      chk("post_rst_nreq", nreq, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpci_dma_sched.md
# cpci_dma_sched

DMA transfer scheduler for the CPCI PCI-master path. It accepts a programmed transfer (direction, host buffer address, length) from the register file and splits it into PCI bursts. It issues those bursts one at a time to the PCI master core, tracks partial completions, target disconnects and aborts, and reports done, error and interrupt status back to the register file. It sits between the DMA register block and the PCI master state machine.

## Interface
- `ADDR_W`, 32: host address width (bytes).
- `LEN_W`, 12: transfer length field width (32-bit words).
- `MAX_BURST`, 16: maximum words per PCI burst (power of two, ≤16).
- `RETRY_MAX`, 255: consecutive zero-progress disconnects before the transfer fails.

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `dma_start`  in  1: one-cycle start pulse. Ignored while busy.
- `dma_dir`  in  1: 0 = read from host, 1 = write to host.
- `dma_host_addr`  in  ADDR_W: start address. Bits [1:0] ignored.
- `dma_len`  in  LEN_W: transfer length in words.
- `dma_busy`  out  1: transfer in progress.
- `dma_done`  out  1: one-cycle pulse at the end of a transfer, whether it succeeded or failed.
- `dma_err`  out  1: sticky error flag; cleared on the next accepted start.
- `dma_err_code`  out  2: 00 none, 01 retry timeout, 10 master abort, 11 target abort.
- `int_en`  in  1: interrupt enable.
- `int_clr`  in  1: pulse; clears the pending interrupt.
- `intr_pend`  out  1: interrupt pending.
- `mst_req`  out  1: burst request to the PCI master core.
- `mst_wr`  out  1: burst direction; equals the latched `dma_dir`.
- `mst_addr`  out  ADDR_W: burst start address, word aligned.
- `mst_cnt`  out  5: burst word count, 1..MAX_BURST.
- `mst_ack`  in  1: master core accepted the request.
- `mst_done`  in  1: burst finished.
- `mst_xfer_cnt`  in  5: words actually transferred in this burst, 0..`mst_cnt`.
- `mst_status`  in  2: 00 complete, 01 disconnect/retry, 10 master abort, 11 target abort.

## Operation
- States: IDLE, REQ, WAIT, UPD, FIN.
- **IDLE**
  - On `dma_start`: latch `dma_dir`, `addr = dma_host_addr & ~3` and `rem = dma_len`.
  - Clear `dma_err`, `dma_err_code` and the retry counter.
  - Go to FIN if `rem == 0`, otherwise go to REQ.
- **REQ**
  - Drive `mst_req`, with `mst_cnt = min(MAX_BURST, rem, 1024 - addr[11:2])`. No burst crosses a 4 KB boundary.
  - `mst_addr`, `mst_cnt` and `mst_wr` stay stable while `mst_req` is high.
  - When `mst_ack` is seen, go to WAIT.
- **WAIT**
  - On `mst_done`: capture `mst_xfer_cnt` and `mst_status`, then go to UPD.
  - `mst_done` is never sampled in the same cycle as `mst_ack`.
- **UPD**
  - Always: `addr += 4*xfer_cnt`, `rem -= xfer_cnt`. The address wraps modulo 2^ADDR_W.
  - Status 10 or 11: set `dma_err` with that code, go to FIN. The partial update is still applied.
  - Status 00 or 01 with `rem == 0`: go to FIN.
  - Status 01 with `xfer_cnt == 0`: increment the retry counter. If it reaches RETRY_MAX, set error code 01 and go to FIN; otherwise go to REQ.
  - Any `xfer_cnt > 0`: clear the retry counter, go to REQ.
  - Status 00 with `rem > 0` after a short `xfer_cnt`: go to REQ. This case is legal.
- **FIN**
  - Pulse `dma_done`.
  - Set `intr_pend` if `int_en` is high.
  - Go to IDLE.
- `intr_pend` is cleared by `int_clr`. If FIN sets it in the same cycle, the set wins.
- `dma_busy` is high in every state except IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, retry counter 0.
- `mst_req` rises one cycle after the `dma_start` cycle.
- After `mst_ack`: `mst_req` is low the next cycle and stays low until UPD completes. Minimum one idle cycle between bursts (WAIT→UPD→REQ).
- `dma_done` is asserted two cycles after the final `mst_done` (UPD, then FIN). `intr_pend` rises in the same cycle as `dma_done`.
- Zero-length start: `dma_done` is asserted one cycle after start, with no `mst_req`.
- Reset mid-transfer: next cycle is IDLE with all outputs 0. An in-flight master burst is abandoned; the master core is reset by the same signal.
- `dma_start` during busy: no effect, no latch update.

## Structure
- Package `cpci_dma_pkg`:
  - state enum;
  - `MST_OK`, `MST_RETRY`, `MST_MABORT`, `MST_TABORT`;
  - `ERR_NONE`, `ERR_RETRY`, `ERR_MABORT`, `ERR_TABORT`.
- Sub-module `cpci_dma_burst_len`: combinational min of MAX_BURST, remaining words and words-to-4KB. Kept separate so it can be tested exhaustively.
- Counters and FSM live in the top module.

## Test plan
- Start addr 0xC0000100, len 128, dir 0, master always completes → 8 bursts of 16 words at 0x100, 0x140, …, 0x2C0; `dma_done` once, `dma_err` 0, `intr_pend` 1 with `int_en` 1.
- Start addr 0xC0000FF0, len 10 → bursts (0xC0000FF0, 4) then (0xC0001000, 6).
- First burst returns status 01 with xfer 5 of 16 → next request at addr+20 with cnt 11; transfer completes with no error.
- Master returns 01 with xfer 0 on every burst, RETRY_MAX 255 → exactly 255 requests, then `dma_err` 1 with code 01 and one `dma_done`.
- Status 10 on the second burst → `dma_err` code 10, `dma_done`, no third request; a following start clears the error.
- Boundary cases:
  - len 0 → `dma_done` at start+1 and no `mst_req`;
  - `int_clr` coinciding with FIN → `intr_pend` stays 1;
  - `reset` asserted during WAIT → all outputs 0 next cycle.
